// File: rtl/writeback_stage_pkg.sv
// Shared types for the EX->WB boundary and the writeback skid buffer.
// The write-back stage and its skid FIFO import everything from here.
package writeback_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        alu_result_ready;
    logic        do_not_execute;
    logic [4:0]  reg_wr_addr;
    logic        rd_wr_en;
  } ex_wb_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic valid, input logic [4:0] rd,
                                           input logic [31:0] data);
    wb_entry_t e;
    e.valid = valid;
    e.rd    = rd;
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/writeback_stage_skid_fifo.sv
// Skid FIFO for ALU results that lost the register-file write port.
// Entries can be invalidated by destination register; invalid entries still pop.
module wb_skid_fifo
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   inval,
  input  logic [4:0]             inval_rd,
  output wb_entry_t              head_entry,
  output wb_entry_t [DEPTH-1:0]  entries,
  output logic [PTR_W-1:0]       head,
  output logic [OCC_W-1:0]       count,
  output logic                   full
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (inval) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rd == inval_rd) begin
            mem[i].valid <= 1'b0;
          end
        end
      end
      // Popped slots are cleared so the forwarding search only sees live data.
      if (pop) begin
        mem[head].valid <= 1'b0;
        head            <= ptr_inc(head);
      end
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= ptr_inc(tail);
      end
      count <= count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_entry = mem[head];
  assign entries    = mem;
  assign full       = (count == OCC_W'(DEPTH));

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates loads and ALU results onto the single
// register-file write port, buffers losing ALU results, forwards pending values.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  ex_wb_t           ex_wb_r,
  input  logic             load_valid,
  input  logic [4:0]       load_rd,
  input  logic [31:0]      load_data,
  output logic             wb_stall,
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  input  logic [4:0]       fwd_rs1_addr,
  input  logic [4:0]       fwd_rs2_addr,
  output logic             fwd_rs1_hit,
  output logic [31:0]      fwd_rs1_data,
  output logic             fwd_rs2_hit,
  output logic [31:0]      fwd_rs2_data,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  ld_acc;
  logic                  alu_acc;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  bypass;
  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [PTR_W-1:0]      fifo_head;
  logic [OCC_W-1:0]      fifo_count;
  wb_entry_t             winner;

  assign ld_acc  = load_valid && (load_rd != REG_ZERO);
  assign alu_acc = ex_wb_r.alu_result_ready && ex_wb_r.rd_wr_en && !ex_wb_r.do_not_execute
                   && (ex_wb_r.reg_wr_addr != REG_ZERO) && !wb_stall;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_pop   = !ld_acc && !fifo_empty;
  assign bypass     = alu_acc && !ld_acc && fifo_empty;
  assign fifo_push  = alu_acc && !bypass;

  // A same-cycle load is younger than the ALU result, so a matching rd kills it on entry.
  assign push_entry = make_entry(!(ld_acc && (load_rd == ex_wb_r.reg_wr_addr)),
                                 ex_wb_r.reg_wr_addr, ex_wb_r.alu_result);

  assign wb_stall = fifo_full;

  wb_skid_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .inval      (ld_acc),
    .inval_rd   (load_rd),
    .head_entry (head_entry),
    .entries    (fifo_entries),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  always_comb begin
    winner = '0;
    if (ld_acc) begin
      winner = make_entry(1'b1, load_rd, load_data);
    end else if (fifo_pop) begin
      winner = head_entry;
    end else if (bypass) begin
      winner = make_entry(1'b1, ex_wb_r.reg_wr_addr, ex_wb_r.alu_result);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      retired_cnt <= '0;
    end else begin
      rf_wr_en <= winner.valid;
      if (winner.valid) begin
        rf_wr_addr <= winner.rd;
        rf_wr_data <= winner.data;
      end
      if (rf_wr_en) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [4:0]       query;
    logic             hit;
    logic [31:0]      data;
    logic [PTR_W-1:0] slot;

    assign query = (gi == 0) ? fwd_rs1_addr : fwd_rs2_addr;

    // Sources are applied oldest first so each younger match overrides the previous one.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      slot = '0;
      if (reset_n && (query != REG_ZERO)) begin
        if (rf_wr_en && (rf_wr_addr == query)) begin
          hit  = 1'b1;
          data = rf_wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
          slot = fifo_head + PTR_W'(k);
          if (fifo_entries[slot].valid && (fifo_entries[slot].rd == query)) begin
            hit  = 1'b1;
            data = fifo_entries[slot].data;
          end
        end
        if (alu_acc && (ex_wb_r.reg_wr_addr == query)) begin
          hit  = 1'b1;
          data = ex_wb_r.alu_result;
        end
        if (ld_acc && (load_rd == query)) begin
          hit  = 1'b1;
          data = load_data;
        end
      end
    end
  end

  assign fwd_rs1_hit  = g_fwd[0].hit;
  assign fwd_rs1_data = g_fwd[0].data;
  assign fwd_rs2_hit  = g_fwd[1].hit;
  assign fwd_rs2_data = g_fwd[1].data;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a queue-based reference model,
// plus directed sequences with hand-computed expectations.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset_n;
  ex_wb_t           ex_wb_r;
  logic             load_valid;
  logic [4:0]       load_rd;
  logic [31:0]      load_data;
  logic             wb_stall;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_addr;
  logic [31:0]      rf_wr_data;
  logic [4:0]       fwd_rs1_addr;
  logic [4:0]       fwd_rs2_addr;
  logic             fwd_rs1_hit;
  logic [31:0]      fwd_rs1_data;
  logic             fwd_rs2_hit;
  logic [31:0]      fwd_rs2_data;
  logic [CNT_W-1:0] retired_cnt;

  writeback_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_wb_r      (ex_wb_r),
    .load_valid   (load_valid),
    .load_rd      (load_rd),
    .load_data    (load_data),
    .wb_stall     (wb_stall),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs2_data (fwd_rs2_data),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid;
    bit [4:0]  rd;
    bit [31:0] data;
  } ment_t;

  ment_t     q[$];
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit [31:0] m_cnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic model_fwd(input bit [4:0] rs, input bit la, input bit aa,
                           output bit hit, output bit [31:0] data);
    hit = 0;
    data = 0;
    if (rs == 0) return;
    if (la && load_rd == rs) begin hit = 1; data = load_data; return; end
    if (aa && ex_wb_r.reg_wr_addr == rs) begin hit = 1; data = ex_wb_r.alu_result; return; end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].rd == rs) begin hit = 1; data = q[i].data; return; end
    end
    if (m_en && m_addr == rs) begin hit = 1; data = m_data; end
  endtask

  // One clock: compare combinational outputs, predict, cross the edge, compare registers.
  task automatic cycle();
    bit stall, la, aa, bypassed, h;
    bit [31:0] d;
    bit n_en;
    bit [4:0] n_addr;
    bit [31:0] n_data;
    ment_t e;
    #3;
    stall = (q.size() == DEPTH);
    check("wb_stall", 32'(wb_stall), 32'(stall));
    la = load_valid && load_rd != 0;
    aa = ex_wb_r.alu_result_ready && ex_wb_r.rd_wr_en && !ex_wb_r.do_not_execute
         && ex_wb_r.reg_wr_addr != 0 && !stall;
    model_fwd(fwd_rs1_addr, la, aa, h, d);
    check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(h));
    check("fwd_rs1_data", fwd_rs1_data, d);
    model_fwd(fwd_rs2_addr, la, aa, h, d);
    check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(h));
    check("fwd_rs2_data", fwd_rs2_data, d);
    n_en = 0; n_addr = m_addr; n_data = m_data; bypassed = 0;
    if (la) begin
      n_en = 1; n_addr = load_rd; n_data = load_data;
      foreach (q[i]) if (q[i].rd == load_rd) q[i].valid = 0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.valid) begin n_en = 1; n_addr = e.rd; n_data = e.data; end
    end else if (aa) begin
      n_en = 1; n_addr = ex_wb_r.reg_wr_addr; n_data = ex_wb_r.alu_result; bypassed = 1;
    end
    if (aa && !bypassed) begin
      e.valid = !(la && load_rd == ex_wb_r.reg_wr_addr);
      e.rd = ex_wb_r.reg_wr_addr;
      e.data = ex_wb_r.alu_result;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (m_en) m_cnt = m_cnt + 1;
    m_en = n_en; m_addr = n_addr; m_data = n_data;
    check("rf_wr_en", 32'(rf_wr_en), 32'(m_en));
    if (m_en) begin
      check("rf_wr_addr", 32'(rf_wr_addr), 32'(m_addr));
      check("rf_wr_data", rf_wr_data, m_data);
    end
    check("retired_cnt", retired_cnt, m_cnt);
  endtask

  task automatic set_idle();
    ex_wb_r = '0;
    load_valid = 0; load_rd = 0; load_data = 0;
    fwd_rs1_addr = 0; fwd_rs2_addr = 0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] data);
    ex_wb_r.alu_result = data;
    ex_wb_r.alu_result_ready = 1;
    ex_wb_r.do_not_execute = 0;
    ex_wb_r.reg_wr_addr = rd;
    ex_wb_r.rd_wr_en = 1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] data);
    load_valid = 1; load_rd = rd; load_data = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_wr_en"}, 32'(rf_wr_en), 32'd0);
    check({tag, "_rf_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    check({tag, "_rf_wr_data"}, rf_wr_data, 32'd0);
    check({tag, "_wb_stall"}, 32'(wb_stall), 32'd0);
    check({tag, "_rs1_hit"}, 32'(fwd_rs1_hit), 32'd0);
    check({tag, "_rs1_data"}, fwd_rs1_data, 32'd0);
    check({tag, "_rs2_hit"}, 32'(fwd_rs2_hit), 32'd0);
    check({tag, "_rs2_data"}, fwd_rs2_data, 32'd0);
    check({tag, "_retired_cnt"}, retired_cnt, 32'd0);
  endtask

  initial begin
    reset_n = 0;
    set_idle();
    model_reset();
    #1;
    check_all_zero("por");
    @(posedge clk);
    #1;
    reset_n = 1;

    // Single ALU write from idle
    set_alu(5'd5, 32'h0000_0011);
    cycle();
    check("t1_en", 32'(rf_wr_en), 32'd1);
    check("t1_addr", 32'(rf_wr_addr), 32'd5);
    check("t1_data", rf_wr_data, 32'h11);
    set_idle();
    cycle();
    check("t1_cnt", retired_cnt, 32'd1);

    // Dropped ALU results and x0 query
    set_alu(5'd0, 32'h1234);
    fwd_rs1_addr = 0;
    #1;
    check("t4_rs1_hit", 32'(fwd_rs1_hit), 32'd0);
    cycle();
    check("t4_rd0_en", 32'(rf_wr_en), 32'd0);
    set_alu(5'd6, 32'h55); ex_wb_r.do_not_execute = 1;
    cycle();
    check("t4_dne_en", 32'(rf_wr_en), 32'd0);
    set_alu(5'd6, 32'h66); ex_wb_r.rd_wr_en = 0;
    cycle();
    check("t4_wen_en", 32'(rf_wr_en), 32'd0);

    // Load beats ALU three cycles in a row; FIFO fills and stalls EX
    set_idle();
    set_load(5'd7, 32'hAAAA_0000);
    set_alu(5'd3, 32'h1);
    cycle();
    check("t2_w1_addr", 32'(rf_wr_addr), 32'd7);
    cycle();
    #1;
    check("t2_stall", 32'(wb_stall), 32'd1);
    cycle();
    set_idle();
    cycle();
    check("t2_drain_addr", 32'(rf_wr_addr), 32'd3);
    check("t2_drain_data", rf_wr_data, 32'h1);
    cycle();
    cycle();

    // Buffered x9 overwritten by a younger load
    set_load(5'd1, 32'h77);
    set_alu(5'd9, 32'h5);
    cycle();
    set_idle();
    set_load(5'd9, 32'h6);
    cycle();
    check("t3_addr", 32'(rf_wr_addr), 32'd9);
    check("t3_data", rf_wr_data, 32'h6);
    set_idle();
    cycle();
    check("t3_no_write", 32'(rf_wr_en), 32'd0);

    // FIFO entry is younger than the rf_wr register for the same rd
    set_load(5'd1, 32'h1);
    set_alu(5'd4, 32'h20);
    cycle();
    set_load(5'd2, 32'h2);
    set_alu(5'd4, 32'h10);
    cycle();
    set_idle();
    cycle();
    check("t5_rf_data", rf_wr_data, 32'h20);
    fwd_rs2_addr = 5'd4;
    #1;
    check("t5_rs2_hit", 32'(fwd_rs2_hit), 32'd1);
    check("t5_rs2_data", fwd_rs2_data, 32'h10);
    cycle();
    set_idle();
    cycle();

    // Asynchronous reset with the FIFO full
    set_load(5'd1, 32'hA);
    set_alu(5'd8, 32'hB);
    cycle();
    set_load(5'd2, 32'hC);
    set_alu(5'd9, 32'hD);
    cycle();
    #1;
    check("t6_full", 32'(wb_stall), 32'd1);
    reset_n = 0;
    #1;
    check_all_zero("t6_rst");
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    cycle();
    check("t6_after_en", 32'(rf_wr_en), 32'd0);

    // Randomized traffic; EX holds its register while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!wb_stall) begin
        ex_wb_r.alu_result = $urandom;
        ex_wb_r.alu_result_ready = ($urandom_range(0, 3) != 0);
        ex_wb_r.do_not_execute = ($urandom_range(0, 9) == 0);
        ex_wb_r.reg_wr_addr = 5'($urandom_range(0, 7));
        ex_wb_r.rd_wr_en = ($urandom_range(0, 9) != 0);
      end
      load_valid = ($urandom_range(0, 2) == 0);
      load_rd = 5'($urandom_range(0, 7));
      load_data = $urandom;
      fwd_rs1_addr = 5'($urandom_range(0, 7));
      fwd_rs2_addr = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
